ble_cmd_rcv: RTL and testbench

UART receive end of the BLE command link. It deserializes the 8N1 byte stream arriving on RX, which a UART transmitter drives. It decodes the ASCII 'g' (8'h67) / 's' (8'h73) commands and runs the power-authorization FSM that produces pwr_up for the balance controller. It sits inside Segway between the RX pin and the balance/steer enable logic.

---
 rtl/ble_pkg.sv | 17 +
 rtl/uart_rx_core.sv | 138 +++++++++++++
 rtl/ble_cmd_rcv.sv | 64 ++++++
 tb/tb_ble_cmd_rcv.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// Shared types and default constants for the BLE command receiver.
// Optional macro PARITY_EN adds the PARITY receive state (8E1 framing).
package ble_pkg;

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

  typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

  localparam logic [7:0] CMD_GO_DEF   = 8'h67;
  localparam logic [7:0] CMD_STOP_DEF = 8'h73;
  localparam int         BAUD_DIV_DEF = 2604;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: RX synchronizer, baud counter, receive FSM, rdy/frm_err and accept pulse.
// Macro PARITY_EN selects 8E1 framing (even parity checked before the stop bit).
module uart_rx_core
  import ble_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_clr_rdy,
  output logic [7:0] o_rx_data,
  output logic       o_rdy,
  output logic       o_frm_err,
  output logic       o_accept
);

  // Reloading BAUD_DIV-1 makes consecutive samples exactly BAUD_DIV clocks apart.
  localparam logic [11:0] HALF_LOAD = 12'(BAUD_DIV / 2);
  localparam logic [11:0] FULL_LOAD = 12'(BAUD_DIV - 1);

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t   r_state, w_state_next;
  logic [11:0] r_baud_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rdy, r_frm_err, r_accept;

  logic w_fall, w_tick;
  logic w_load_half, w_load_full, w_start_ok, w_shift_en, w_stop_smp;
  logic w_par_smp;
  logic w_good, w_bad;

  assign w_fall = r_rx_prev & ~r_rx_sync;
  assign w_tick = (r_baud_cnt == 12'd0);

  always_comb begin
    w_state_next = r_state;
    w_load_half  = 1'b0;
    w_load_full  = 1'b0;
    w_start_ok   = 1'b0;
    w_shift_en   = 1'b0;
    w_stop_smp   = 1'b0;
    w_par_smp    = 1'b0;
    case (r_state)
      IDLE: if (w_fall) begin
        w_state_next = START;
        w_load_half  = 1'b1;
      end
      START: if (w_tick) begin
        if (r_rx_sync) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DATA;
          w_load_full  = 1'b1;
          w_start_ok   = 1'b1;
        end
      end
      DATA: if (w_tick) begin
        w_shift_en  = 1'b1;
        w_load_full = 1'b1;
`ifdef PARITY_EN
        if (r_bit_cnt == 4'd7) w_state_next = PARITY;
`else
        if (r_bit_cnt == 4'd7) w_state_next = STOP;
`endif
      end
`ifdef PARITY_EN
      PARITY: if (w_tick) begin
        w_par_smp    = 1'b1;
        w_load_full  = 1'b1;
        w_state_next = STOP;
      end
`endif
      STOP: if (w_tick) begin
        w_stop_smp   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef PARITY_EN
  logic r_par_err;
  assign w_good = w_stop_smp & r_rx_sync & ~r_par_err;
`else
  assign w_good = w_stop_smp & r_rx_sync;
`endif
  assign w_bad = w_stop_smp & ~w_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_state    <= IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_accept   <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_next;
      if (w_load_half)      r_baud_cnt <= HALF_LOAD;
      else if (w_load_full) r_baud_cnt <= FULL_LOAD;
      else if (!w_tick)     r_baud_cnt <= r_baud_cnt - 12'd1;
      if (w_start_ok)      r_bit_cnt <= 4'd0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 4'd1;
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
      if (w_good) r_rx_data <= r_shift;
      // rdy is dropped only once a start bit is confirmed, so a glitch leaves it intact.
      if (w_good)                       r_rdy <= 1'b1;
      else if (i_clr_rdy || w_start_ok) r_rdy <= 1'b0;
      r_frm_err <= w_bad;
      r_accept  <= w_good;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_par_err <= 1'b0;
    else if (w_start_ok) r_par_err <= 1'b0;
    else if (w_par_smp)  r_par_err <= (^r_shift) ^ r_rx_sync;
  end
`endif

  assign o_rx_data = r_rx_data;
  assign o_rdy     = r_rdy;
  assign o_frm_err = r_frm_err;
  assign o_accept  = r_accept;

endmodule

// File: rtl/ble_cmd_rcv.sv
// BLE command link receiver: UART core plus the 'g'/'s' power-authorization FSM driving pwr_up.
// Macro PARITY_EN switches the link to 8E1 framing.
module ble_cmd_rcv
  import ble_pkg::*;
#(
  parameter int         BAUD_DIV = BAUD_DIV_DEF,
  parameter logic [7:0] CMD_GO   = CMD_GO_DEF,
  parameter logic [7:0] CMD_STOP = CMD_STOP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  logic [7:0]  w_rx_data;
  logic        w_accept;
  auth_state_t r_auth, w_auth_next;
  logic        r_pwr_up;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx      (RX),
    .i_clr_rdy (clr_rdy),
    .o_rx_data (w_rx_data),
    .o_rdy     (rdy),
    .o_frm_err (frm_err),
    .o_accept  (w_accept)
  );

  always_comb begin
    w_auth_next = r_auth;
    case (r_auth)
      OFF:  if (w_accept && w_rx_data == CMD_GO) w_auth_next = PWR1;
      PWR1: if (w_accept && w_rx_data == CMD_STOP) w_auth_next = rider_off ? OFF : PWR2;
      // A GO arriving together with rider_off keeps power on.
      PWR2: if (w_accept && w_rx_data == CMD_GO) w_auth_next = PWR1;
            else if (rider_off)                  w_auth_next = OFF;
      default: w_auth_next = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auth   <= OFF;
      r_pwr_up <= 1'b0;
    end else begin
      r_auth   <= w_auth_next;
      r_pwr_up <= (w_auth_next != OFF);
    end
  end

  assign rx_data = w_rx_data;
  assign pwr_up  = r_pwr_up;

endmodule

// File: tb/tb_ble_cmd_rcv.sv
// Self-checking bench for ble_cmd_rcv: bench UART transmitter, event-level model, per-cycle compare.
// Honours PARITY_EN when the design is built with it.
module tb_ble_cmd_rcv;

  localparam int         D   = 32;
  localparam logic [7:0] GO  = 8'h67;
  localparam logic [7:0] ST  = 8'h73;
`ifdef PARITY_EN
  localparam int LAT_NOM = 19 * D / 2 + D;
`else
  localparam int LAT_NOM = 19 * D / 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, pwr_up;

  ble_cmd_rcv #(.BAUD_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .clr_rdy   (clr_rdy),
    .rider_off (rider_off),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .frm_err   (frm_err),
    .pwr_up    (pwr_up)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit stable = 1'b0;

  // Model: last good byte, rdy flag, powered flag, pending stop request, framing error count.
  logic [7:0] m_data = 8'h00;
  bit         m_rdy = 1'b0;
  bit         m_pwr = 1'b0;
  bit         m_req = 1'b0;
  int         m_ferr = 0;
  int         ferr_seen = 0;
  logic       prev_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_err) begin
        ferr_seen <= ferr_seen + 1;
        chk("frm_err_one_clk", 32'(prev_ferr), 32'd0);
      end
      prev_ferr <= frm_err;
      if (stable) begin
        chk("rdy", 32'(rdy), 32'(m_rdy));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("pwr_up", 32'(pwr_up), 32'(m_pwr));
        chk("frm_err_idle", 32'(frm_err), 32'd0);
      end
    end else begin
      prev_ferr <= 1'b0;
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_accept(input logic [7:0] b);
    if (b == GO) begin
      m_pwr = 1'b1;
      m_req = 1'b0;
    end else if (b == ST && m_pwr && !m_req) begin
      if (rider_off) m_pwr = 1'b0;
      else           m_req = 1'b1;
    end
    if (m_req && rider_off) begin
      m_pwr = 1'b0;
      m_req = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    stable = 1'b0;
    RX = 1'b0;
    clk_n(D);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      clk_n(D);
      if (i == 3) chk("rdy_mid_frame", 32'(rdy), 32'd0);
    end
`ifdef PARITY_EN
    RX = (^b) ^ !par_ok;
    clk_n(D);
`endif
    RX = stop_ok;
    clk_n(D);
    RX = 1'b1;
    clk_n(2);
    if (stop_ok && par_ok) begin
      m_data = b;
      m_rdy  = 1'b1;
      m_accept(b);
    end else begin
      m_rdy = 1'b0;
      m_ferr++;
    end
    chk("frm_err_count", 32'(ferr_seen), 32'(m_ferr));
    $display("frame byte=%02h stop=%0d par=%0d -> rdy=%0d rx_data=%02h pwr_up=%0d",
             b, stop_ok, par_ok, rdy, rx_data, pwr_up);
    stable = 1'b1;
  endtask

  task automatic frame_timed(input logic [7:0] b, input bit pwr_before, input bit pwr_after);
    int c0;
    c0 = cyc;
    fork
      send_frame(b, 1'b1, 1'b1);
      begin
        bit got;
        int lat;
        got = 1'b0;
        clk_n(5 * D);
        for (int k = 0; k < 8 * D && !got; k++) begin
          @(negedge clk);
          if (rdy) got = 1'b1;
        end
        chk("rdy_timeout", 32'(got), 32'd1);
        if (got) begin
          lat = cyc - c0;
          chk("latency_window", 32'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 8), 32'd1);
          chk("pwr_at_accept", 32'(pwr_up), 32'(pwr_before));
          @(negedge clk);
          chk("pwr_after_accept", 32'(pwr_up), 32'(pwr_after));
        end
      end
    join
  endtask

  task automatic do_clr();
    stable = 1'b0;
    clr_rdy = 1'b1;
    clk_n(1);
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    $display("clr_rdy pulse -> rdy=%0d", rdy);
    stable = 1'b1;
  endtask

  task automatic set_rider(input logic v);
    stable = 1'b0;
    rider_off = v;
    clk_n(2);
    if (v && m_req) begin
      m_pwr = 1'b0;
      m_req = 1'b0;
    end
    $display("rider_off=%0d -> pwr_up=%0d", v, pwr_up);
    stable = 1'b1;
  endtask

  task automatic glitch();
    int f0;
    f0 = ferr_seen;
    stable = 1'b0;
    RX = 1'b0;
    clk_n(D / 4);
    RX = 1'b1;
    clk_n(D);
    chk("glitch_no_ferr", 32'(ferr_seen), 32'(f0));
    chk("glitch_rdy", 32'(rdy), 32'(m_rdy));
    $display("glitch %0d clks -> rdy=%0d", D / 4, rdy);
    stable = 1'b1;
  endtask

  initial begin
    int f0;
    bit got;
    logic [7:0] b;
    bit stop_ok, par_ok;

    // Reset values
    clk_n(3);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_frm_err", 32'(frm_err), 32'd0);
    chk("reset_pwr_up", 32'(pwr_up), 32'd0);
    rst_n = 1'b1;
    clk_n(2);
    stable = 1'b1;

    // 'g' powers up one clock after the accept
    frame_timed(GO, 1'b0, 1'b1);
    chk("go_rx_data", 32'(rx_data), 32'h67);
    chk("go_rdy", 32'(rdy), 32'd1);

    // 's' with rider present keeps power; rider leaving drops it
    frame_timed(ST, 1'b1, 1'b1);
    chk("pwr2_held", 32'(pwr_up), 32'd1);
    set_rider(1'b1);
    chk("rider_off_drop", 32'(pwr_up), 32'd0);

    // 'g' then 's' with rider off: power drops one clock after the accept
    frame_timed(GO, 1'b0, 1'b1);
    frame_timed(ST, 1'b1, 1'b0);
    chk("stop_rider_off", 32'(pwr_up), 32'd0);
    set_rider(1'b0);

    // Short glitch is a false start; following byte still received
    glitch();
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("after_glitch_data", 32'(rx_data), 32'hA5);

    // Bad stop bit: one frm_err pulse, nothing delivered
    do_clr();
    f0 = ferr_seen;
    send_frame(GO, 1'b0, 1'b1);
    chk("badstop_ferr", 32'(ferr_seen - f0), 32'd1);
    chk("badstop_rdy", 32'(rdy), 32'd0);
    chk("badstop_pwr", 32'(pwr_up), 32'd0);
`ifdef PARITY_EN
    send_frame(GO, 1'b1, 1'b0);
    chk("badpar_pwr", 32'(pwr_up), 32'd0);
`endif

    // Overrun and set-beats-clear
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    chk("overrun_data", 32'(rx_data), 32'h34);
    chk("overrun_rdy", 32'(rdy), 32'd1);
    fork
      send_frame(8'h56, 1'b1, 1'b1);
      begin
        clk_n(5 * D);
        clr_rdy = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 * D && !got; k++) begin
          @(negedge clk);
          if (rdy) got = 1'b1;
        end
        clr_rdy = 1'b0;
        chk("set_beats_clear", 32'(got), 32'd1);
      end
    join
    chk("coincident_rdy", 32'(rdy), 32'd1);
    chk("coincident_data", 32'(rx_data), 32'h56);

    // Reset mid-frame abandons the frame
    frame_timed(GO, 1'b0, 1'b1);
    stable = 1'b0;
    RX = 1'b0;
    clk_n(3 * D);
    rst_n = 1'b0;
    RX = 1'b1;
    clk_n(2);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'h00);
    chk("midrst_pwr", 32'(pwr_up), 32'd0);
    rst_n = 1'b1;
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_pwr = 1'b0;
    m_req = 1'b0;
    f0 = ferr_seen;
    clk_n(12 * D);
    chk("midrst_no_ferr", 32'(ferr_seen), 32'(f0));
    stable = 1'b1;

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)       set_rider(~rider_off);
      else if (r < 4)  do_clr();
      else if (r == 4) glitch();
      case ($urandom_range(0, 2))
        0:       b = GO;
        1:       b = ST;
        default: b = 8'($urandom_range(0, 255));
      endcase
      stop_ok = ($urandom_range(0, 7) != 0);
`ifdef PARITY_EN
      par_ok = ($urandom_range(0, 7) != 0);
`else
      par_ok = 1'b1;
`endif
      send_frame(b, stop_ok, par_ok);
      clk_n($urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
